// File: rtl/addsub_arbiter.sv
// Two-requester arbiter feeding one shared ripple add/subtract unit.
// A winner's operands are latched, evaluated for one cycle, and returned with a done pulse.
module addsub_arbiter #(
  parameter int WIDTH = 4,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_cout,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               win_q, win_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   d_s;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH:0]     carry_s;
  logic               sel1_s;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple chain; subtract is b + ~a + 1, so carry-out means "no borrow".
  always_comb begin
    d_s        = a_q ^ {WIDTH{op_q}};
    sum_s      = {WIDTH{1'b0}};
    carry_s    = {(WIDTH+1){1'b0}};
    carry_s[0] = op_q;
    for (int i = 0; i < WIDTH; i++) begin
      {carry_s[i+1], sum_s[i]} = full_add(d_s[i], b_q[i], carry_s[i]);
    end
  end

  // Requester 1 wins when alone, or when both ask and the round-robin pointer names it.
  always_comb begin
    if (req1 && (!req0 || ((FAIR == 1'b1) && ptr_q))) begin
      sel1_s = 1'b1;
    end else begin
      sel1_s = 1'b0;
    end
  end

  // Next-state and output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cout_d  = cout_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = sel1_s;
          a_d     = sel1_s ? a1 : a0;
          b_d     = sel1_s ? b1 : b0;
          op_d    = sel1_s ? op1 : op0;
          gnt0_d  = ~sel1_s;
          gnt1_d  = sel1_s;
          busy_d  = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d   = sum_s;
        cout_d  = carry_s[WIDTH];
        done0_d = ~win_q;
        done1_d = win_q;
        if (FAIR == 1'b1) begin
          ptr_d = ~ptr_q;
        end else begin
          ptr_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign res_cout = cout_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are checked against an arithmetic/arbitration reference model.
module tb_addsub_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic f_gnt0, f_gnt1, f_done0, f_done1, f_cout, f_busy;
  logic [W-1:0] f_res;
  logic x_gnt0, x_gnt1, x_done0, x_done1, x_cout, x_busy;
  logic [W-1:0] x_res;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W), .FAIR(1'b1)) u_fair (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .res(f_res), .res_cout(f_cout), .busy(f_busy));

  addsub_arbiter #(.WIDTH(W), .FAIR(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(x_gnt0), .gnt1(x_gnt1), .done0(x_done0), .done1(x_done1),
    .res(x_res), .res_cout(x_cout), .busy(x_busy));

  // Reference arithmetic: returns {cout, result} using plain integer math.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int s;
    logic [W:0] r;
    if (!op) begin
      s = int'(a) + int'(b);
      r = {s >= (1 << W), W'(s % (1 << W))};
    end else begin
      s = (int'(b) - int'(a) + (1 << W)) % (1 << W);
      r = {b >= a, W'(s)};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    apply_reset();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; op0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    n_vec++;
    if (f_res !== 4'd8 || f_done0 !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_op: res=%0d done0=%b expected res=8 done0=1", f_res, f_done0);
    end
    #3 rst_n = 1'b0;
    #1;
    got = {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_cout, f_res};
    n_vec++;
    if (got !== 10'b0) begin
      n_err++; $display("FAIL async_reset_fair: outputs=%b expected all zero", got);
    end
    got = {x_gnt0, x_gnt1, x_done0, x_done1, x_busy, x_cout, x_res};
    n_vec++;
    if (got !== 10'b0) begin
      n_err++; $display("FAIL async_reset_fixed: outputs=%b expected all zero", got);
    end
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_vec++;
    if ({f_gnt0, f_gnt1} !== 2'b10) begin
      n_err++; $display("FAIL reset_pointer: gnt0/gnt1=%b%b expected 10", f_gnt0, f_gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_add();
    apply_reset();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; op0 = 1'b0;
    tick();
    n_vec++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_busy} !== 5'b10001) begin
      n_err++; $display("FAIL add_grant: g0 g1 d0 d1 busy=%b expected 10001", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy});
    end
    req0 = 1'b0; a0 = 4'd9; b0 = 4'd9;
    tick();
    n_vec++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_cout, f_res} !== {5'b00100, 1'b0, 4'd8}) begin
      n_err++; $display("FAIL add_result: flags=%b cout=%b res=%0d expected 00100 0 8", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy}, f_cout, f_res);
    end
    tick();
    n_vec++;
    if ({f_done0, f_cout, f_res} !== {1'b0, 1'b0, 4'd8}) begin
      n_err++; $display("FAIL add_hold: done0=%b cout=%b res=%0d expected 0 0 8", f_done0, f_cout, f_res);
    end
  endtask

  task automatic test_req1_arith();
    logic [W-1:0] ta [3] = '{4'd15, 4'd3, 4'd5};
    logic [W-1:0] tb [3] = '{4'd1, 4'd5, 4'd3};
    logic         to [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] tr [3] = '{4'd0, 4'd2, 4'd14};
    logic         tc [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1; a1 = ta[i]; b1 = tb[i]; op1 = to[i];
      tick();
      n_vec++;
      if ({f_gnt0, f_gnt1, f_busy} !== 3'b011) begin
        n_err++; $display("FAIL req1_grant[%0d]: g0 g1 busy=%b expected 011", i, {f_gnt0, f_gnt1, f_busy});
      end
      req1 = 1'b0; a1 = ~a1;
      tick();
      n_vec++;
      if ({f_done0, f_done1, f_cout, f_res} !== {1'b0, 1'b1, tc[i], tr[i]}) begin
        n_err++; $display("FAIL req1_result[%0d]: d0 d1=%b%b cout=%b res=%0d expected 01 %b %0d", i, f_done0, f_done1, f_cout, f_res, tc[i], tr[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [W:0] exp;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
      exp = (k % 2 == 0) ? model(a0, b0, op0) : model(a1, b1, op1);
      tick();
      n_vec++;
      if ({f_gnt0, f_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_grant[%0d]: gnt0/gnt1=%b%b expected winner %0d", k, f_gnt0, f_gnt1, k % 2);
      end
      if (k % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      n_vec++;
      if ({f_done0, f_done1, f_cout, f_res} !== {((k % 2 == 0) ? 2'b10 : 2'b01), exp}) begin
        n_err++; $display("FAIL rr_done[%0d]: d0 d1=%b%b cout/res=%b expected winner %0d cout/res=%b", k, f_done0, f_done1, {f_cout, f_res}, k % 2, exp);
      end
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++;
      if ({x_gnt0, x_gnt1, x_done0} !== {(k % 2 == 1), 1'b0, (k % 2 == 0)}) begin
        n_err++; $display("FAIL fixed_prio[%0d]: gnt0 gnt1 done0=%b expected %b0%b", k, {x_gnt0, x_gnt1, x_done0}, (k % 2 == 1), (k % 2 == 0));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_exec();
    logic [9:0] got;
    apply_reset();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; op0 = 1'b0;
    tick();
    n_vec++;
    if (f_gnt0 !== 1'b1) begin
      n_err++; $display("FAIL rexec_grant: gnt0=%b expected 1", f_gnt0);
    end
    req0 = 1'b0; req1 = 1'b1; a1 = 4'd5; b1 = 4'd3; op1 = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    got = {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_cout, f_res};
    n_vec++;
    if (got !== 10'b0) begin
      n_err++; $display("FAIL rexec_discard: outputs=%b expected all zero (no done0)", got);
    end
    rst_n = 1'b1;
    ptr_m = 0;
    tick();
    n_vec++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_busy} !== 5'b01001) begin
      n_err++; $display("FAIL rexec_req1_grant: g0 g1 d0 d1 busy=%b expected 01001", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy});
    end
    req1 = 1'b0;
    tick();
    n_vec++;
    if ({f_done0, f_done1, f_cout, f_res} !== {2'b01, 1'b0, 4'd14}) begin
      n_err++; $display("FAIL rexec_req1_result: d0 d1=%b%b cout=%b res=%0d expected 01 0 14", f_done0, f_done1, f_cout, f_res);
    end
  endtask

  task automatic test_random();
    int r, wf, wx;
    logic [W:0] ef, ex;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      req0 = r[0]; req1 = r[1];
      a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
      wf = (req0 && req1) ? ptr_m : (req1 ? 1 : 0);
      wx = req0 ? 0 : 1;
      ef = (wf == 1) ? model(a1, b1, op1) : model(a0, b0, op0);
      ex = (wx == 1) ? model(a1, b1, op1) : model(a0, b0, op0);
      tick();
      n_vec++;
      if ({f_gnt0, f_gnt1, f_busy, x_gnt0, x_gnt1, x_busy} !== {wf == 0, wf == 1, 1'b1, wx == 0, wx == 1, 1'b1}) begin
        n_err++; $display("FAIL rand_grant[%0d]: fair g0g1b=%b fixed g0g1b=%b expected winners %0d/%0d", i, {f_gnt0, f_gnt1, f_busy}, {x_gnt0, x_gnt1, x_busy}, wf, wx);
      end
      req0 = 1'b0; req1 = 1'b0;
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      tick();
      ptr_m = 1 - ptr_m;
      n_vec++;
      if ({f_done0, f_done1, f_cout, f_res, x_done0, x_done1, x_cout, x_res} !== {wf == 0, wf == 1, ef, wx == 0, wx == 1, ex}) begin
        n_err++; $display("FAIL rand_result[%0d]: fair d/cout/res=%b%b %b fixed=%b%b %b expected %b %b", i, f_done0, f_done1, {f_cout, f_res}, x_done0, x_done1, {x_cout, x_res}, ef, ex);
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        n_vec++;
        if ({f_done0, f_done1, f_busy, f_cout, f_res} !== {3'b000, ef}) begin
          n_err++; $display("FAIL rand_hold[%0d]: d0 d1 busy=%b cout/res=%b expected 000 %b", i, {f_done0, f_done1, f_busy}, {f_cout, f_res}, ef);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_req1_arith();
    test_round_robin();
    test_fixed_priority();
    test_reset_in_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Two-requester arbiter and sequencer for one shared WIDTH-bit ripple add/subtract unit built from full-adder cells.
- Latches the winning requester's operands, runs the shared datapath for one cycle, and returns a registered result with a per-requester done pulse.
- Sits between two client blocks that previously each needed their own add/sub instance.

Parameters:
- WIDTH, 4: operand/result width; number of full-adder cells in the ripple chain.
- FAIR, 1: 1 = round-robin priority; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0, req1  input  1  level request from requester 0/1.
- a0, b0, op0  input  WIDTH, WIDTH, 1  operands and op of requester 0; op 0 = add, 1 = subtract.
- a1, b1, op1  input  WIDTH, WIDTH, 1  same for requester 1.
- gnt0, gnt1  output  1  grant; one-cycle pulse, one-hot.
- done0, done1  output  1  result-valid; one-cycle pulse, one-hot.
- res  output  WIDTH  shared result register.
- res_cout  output  1  carry-out of the chain.
- busy  output  1  high while state is EXEC.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; pointer = requester 0.
  - gnt0/1, done0/1, res, res_cout and busy are all 0.
  - Any in-flight operation is discarded; no done is issued for it.
- State machine, two states:
  - IDLE: at a rising edge with req0 or req1 high:
    - Select the winner (see Arbitration).
    - Load operand registers (a, b, op) from the winner.
    - Set the winner's gnt to 1 and busy to 1; go to EXEC.
    - With no request, stay in IDLE; all pulses are 0.
  - EXEC: the datapath evaluates combinationally from the operand registers. At the next edge:
    - Load res and res_cout.
    - Pulse the matching done for one cycle; clear gnt and busy.
    - If FAIR = 1, flip the pointer to the other requester.
    - Go to IDLE.
    - req inputs are ignored in EXEC.
- Timing:
  - Request sampled at edge N: gnt visible in cycle N..N+1; done, res and res_cout valid after edge N+1.
  - Latency is 2 edges; throughput is one operation per 2 cycles.
  - A new request is sampled no earlier than edge N+2.
- Handshake:
  - Requester holds req and its operands stable until it sees gnt.
  - It must drop req before the edge following gnt, or the held req is taken as a new request at edge N+2.
  - Operands may change freely after gnt; they are already latched.
- Arbitration:
  - Only one requester active: it wins.
  - Both active, FAIR = 1: the requester named by the pointer wins.
  - Both active, FAIR = 0: requester 0 wins; requester 1 can starve, and this is intended.
- Arithmetic, mod 2^WIDTH:
  - The ripple chain takes d = a XOR {WIDTH{op}}, b, and carry-in = op.
  - op = 0: res = a + b; res_cout = carry out of the MSB.
  - op = 1: res = b - a (note operand order); res_cout = 1 when b >= a (no borrow), 0 otherwise.
- Output hold:
  - res and res_cout hold their value until the next EXEC completes.
  - They are not cleared when done falls.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; pointer = 0.
- Add: req0 = 1, a0 = 3, b0 = 5, op0 = 0 at edge N -> gnt0 = 1 in cycle N; done0 = 1, res = 8, res_cout = 0 after edge N+1.
- Wrap and subtract, requester 1:
  - a1 = 15, b1 = 1, op1 = 0 -> res = 0, res_cout = 1.
  - a1 = 3, b1 = 5, op1 = 1 -> res = 2, res_cout = 1.
  - a1 = 5, b1 = 3, op1 = 1 -> res = 14, res_cout = 0.
- Round-robin, FAIR = 1: req0 and req1 both held high from reset, each dropped after its gnt and reasserted -> grants alternate 0, 1, 0, 1 at 2-cycle spacing; done matches gnt each time.
- Fixed priority, FAIR = 0: req0 and req1 both held high continuously -> gnt0 every 2 cycles, gnt1 never asserted.
- Reset in EXEC: rst_n low the cycle after gnt0 -> no done0; res = 0; state returns to IDLE; after release, a pending req1 is granted first-sample.
